// File: rtl/lu_pkg.sv
// Shared definitions for the 2-bit logic unit, its sequencer and their benches.
package lu_pkg;

  // Opcode map for {i1,i0}
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_XNOR = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  // Sequencer state encoding
  localparam logic [2:0] ST_LD_A   = 3'd0;
  localparam logic [2:0] ST_LD_B   = 3'd1;
  localparam logic [2:0] ST_LD_OP  = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

endpackage

// File: rtl/lu_golden.sv
// Combinational golden model of the 2-bit logic unit.
module lu_golden
  import lu_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic [1:0] op_i,
  output logic [1:0] f_o
);

  // Bitwise function selected by the opcode; NOT-A ignores b
  always_comb begin
    f_o = 2'b00;
    case (op_i)
      OP_AND:  f_o = a_i & b_i;
      OP_OR:   f_o = a_i | b_i;
      OP_XNOR: f_o = ~(a_i ^ b_i);
      default: f_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/lu_cmd_sequencer.sv
// Collects A, B and opcode words, issues them to the logic unit, captures its
// result and hands it off with a golden-model mismatch flag and an op counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LD_A   | waiting for operand A word
// ST_LD_B   | waiting for operand B word
// ST_LD_OP  | waiting for opcode word; acceptance loads the unit drivers
// ST_ISSUE  | a/b/i held on the unit, wait-counter running, then sample f
// ST_RESULT | result presented on out_*, waiting for out_ready
module lu_cmd_sequencer
  import lu_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned ISSUE_WS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_data,
  output logic [1:0]       lu_a,
  output logic [1:0]       lu_b,
  output logic             lu_i0,
  output logic             lu_i1,
  input  logic [1:0]       lu_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_f,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned WS_W = (ISSUE_WS < 2) ? 1 : $clog2(ISSUE_WS + 1);

  logic [2:0]       state_q;
  logic [1:0]       a_q;
  logic [1:0]       b_q;
  logic [1:0]       lu_a_q;
  logic [1:0]       lu_b_q;
  logic [1:0]       lu_i_q;
  logic [WS_W-1:0]  wait_q;
  logic [1:0]       out_f_q;
  logic             out_err_q;
  logic [CNT_W-1:0] op_count_q;
  logic [1:0]       gold_f;

  // The golden model looks at exactly what is driven onto the unit
  lu_golden u_golden (
    .a_i  (lu_a_q),
    .b_i  (lu_b_q),
    .op_i (lu_i_q),
    .f_o  (gold_f)
  );

  // FSM, operand/driver registers, wait down-counter, result capture and op counter.
  // The unit drivers are loaded on opcode acceptance so they are stable for the
  // whole ISSUE state; ISSUE then spends one settle cycle plus ISSUE_WS hold
  // cycles before f is sampled at the wait-counter terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LD_A;
      a_q        <= '0;
      b_q        <= '0;
      lu_a_q     <= '0;
      lu_b_q     <= '0;
      lu_i_q     <= '0;
      wait_q     <= '0;
      out_f_q    <= '0;
      out_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state_q)
        ST_LD_A: begin
          if (in_valid) begin
            a_q     <= in_data;
            state_q <= ST_LD_B;
          end
        end
        ST_LD_B: begin
          if (in_valid) begin
            b_q     <= in_data;
            state_q <= ST_LD_OP;
          end
        end
        ST_LD_OP: begin
          if (in_valid) begin
            lu_a_q  <= a_q;
            lu_b_q  <= b_q;
            lu_i_q  <= in_data;
            wait_q  <= WS_W'(ISSUE_WS);
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wait_q == '0) begin
            out_f_q   <= lu_f;
            out_err_q <= (lu_f != gold_f);
            state_q   <= ST_RESULT;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            op_count_q <= op_count_q + 1'b1;
            state_q    <= ST_LD_A;
          end
        end
        default: state_q <= ST_LD_A;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_LD_A) || (state_q == ST_LD_B) || (state_q == ST_LD_OP);
  assign out_valid = (state_q == ST_RESULT);
  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_i0     = lu_i_q[0];
  assign lu_i1     = lu_i_q[1];
  assign out_f     = out_f_q;
  assign out_err   = out_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_lu_cmd_sequencer.sv
// Self-checking bench for lu_cmd_sequencer with a behavioural logic-unit stub.
module tb_lu_cmd_sequencer;
  import lu_pkg::*;

  localparam int CNT_W    = 4;
  localparam int ISSUE_WS = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_data = 2'b00;
  logic [1:0]       lu_a;
  logic [1:0]       lu_b;
  logic             lu_i0;
  logic             lu_i1;
  logic [1:0]       lu_f;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_f;
  logic             out_err;
  logic [CNT_W-1:0] op_count;

  logic stuck = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  // Reference: evaluate each bit from the opcode's truth rule
  function automatic logic [1:0] ref_f(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op);
    logic [1:0] r;
    r = 2'b00;
    for (int k = 0; k < 2; k++) begin
      case (op)
        2'b00:   r[k] = a[k] && b[k];
        2'b10:   r[k] = a[k] || b[k];
        2'b01:   r[k] = (a[k] == b[k]);
        default: r[k] = !a[k];
      endcase
    end
    return r;
  endfunction

  assign lu_f = stuck ? 2'b00 : ref_f(lu_a, lu_b, {lu_i1, lu_i0});

  lu_cmd_sequencer #(.CNT_W(CNT_W), .ISSUE_WS(ISSUE_WS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_i0     (lu_i0),
    .lu_i1     (lu_i1),
    .lu_f      (lu_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_err   (out_err),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one word and hold it until the sequencer takes it (bounded)
  task automatic send_word(input logic [1:0] w);
    bit ok;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_word", 8'(ok), 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One full operation with fixed-latency, backpressure and handoff checks
  task automatic run_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                        input bit fault, input int hold);
    logic [1:0] r;
    logic [1:0] ef;
    logic       ee;
    r  = ref_f(a, b, op);
    ef = fault ? 2'b00 : r;
    ee = (ef != r);
    stuck = fault;
    send_word(a);
    send_word(b);
    send_word(op);
    @(negedge clk);
    check("issue_valid0", 8'(out_valid), 8'd0);
    check("issue_ready0", 8'(in_ready), 8'd0);
    check("issue_lu_a", 8'(lu_a), 8'(a));
    check("issue_lu_b", 8'(lu_b), 8'(b));
    check("issue_lu_i", 8'({lu_i1, lu_i0}), 8'(op));
    for (int w = 0; w < ISSUE_WS; w++) begin
      @(negedge clk);
      check("issue_wait_valid0", 8'(out_valid), 8'd0);
    end
    @(negedge clk);
    check("result_valid", 8'(out_valid), 8'd1);
    check("result_f", 8'(out_f), 8'(ef));
    check("result_err", 8'(out_err), 8'(ee));
    check("result_ready0", 8'(in_ready), 8'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("hold_valid", 8'(out_valid), 8'd1);
      check("hold_f", 8'(out_f), 8'(ef));
      check("hold_ready0", 8'(in_ready), 8'd0);
      check("hold_count", 8'(op_count), 8'(exp_count));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    stuck = 1'b0;
    check("handoff_valid0", 8'(out_valid), 8'd0);
    check("handoff_ready1", 8'(in_ready), 8'd1);
    check("handoff_count", 8'(op_count), 8'(exp_count));
    check("handoff_lu_a_kept", 8'(lu_a), 8'(a));
    check("handoff_lu_i_kept", 8'({lu_i1, lu_i0}), 8'(op));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_op_count", 8'(op_count), 8'd0);
    check("rst_lu", 8'({lu_a, lu_b, lu_i1, lu_i0}), 8'd0);
    check("rst_out", 8'({out_f, out_err}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // AND, then each remaining opcode
    run_op(2'b11, 2'b01, OP_AND, 1'b0, 0);
    check("first_count", 8'(op_count), 8'd1);
    run_op(2'b10, 2'b11, OP_OR, 1'b0, 0);
    run_op(2'b10, 2'b11, OP_XNOR, 1'b0, 0);
    run_op(2'b10, 2'b11, OP_NOTA, 1'b0, 0);

    // Backpressure with junk on the input side
    run_op(2'b01, 2'b11, OP_XNOR, 1'b0, 5);

    // Unit stuck at zero
    run_op(2'b01, 2'b01, OP_OR, 1'b1, 1);

    // Reset after A and B are loaded
    send_word(2'b11);
    send_word(2'b10);
    rst_n = 1'b0;
    #3;
    check("midrst_in_ready", 8'(in_ready), 8'd1);
    check("midrst_out_valid", 8'(out_valid), 8'd0);
    check("midrst_op_count", 8'(op_count), 8'd0);
    check("midrst_lu", 8'({lu_a, lu_b, lu_i1, lu_i0}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    @(posedge clk);
    #1;
    run_op(2'b01, 2'b10, OP_NOTA, 1'b0, 0);

    // Random operations carrying the counter past its wrap
    for (int t = 0; t < (1 << CNT_W); t++) begin
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end
    check("wrap_count", 8'(op_count), 8'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
